// File: rtl/rx_byte_word_packer_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_byte_word_packer_if
//  Description : Byte-stream input and packed-word output bundle between the
//                OFDM receiver byte decoder and the RX byte-to-word packer.
//                The master side is the receiver/stimulus; the slave side is
//                the packer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rx_byte_word_packer_if;
  logic        pkt_start;
  logic [7:0]  byte_in;
  logic        byte_in_strobe;
  logic [15:0] byte_count;
  logic [15:0] num_byte;
  logic        fcs_in_strobe;
  logic        fcs_ok;
  logic        rx_pkt_sn_plus_one;
  logic [63:0] word_out;
  logic        word_out_strobe;

  modport master (
    output pkt_start, byte_in, byte_in_strobe, byte_count, num_byte,
           fcs_in_strobe, fcs_ok, rx_pkt_sn_plus_one,
    input  word_out, word_out_strobe
  );

  modport slave (
    input  pkt_start, byte_in, byte_in_strobe, byte_count, num_byte,
           fcs_in_strobe, fcs_ok, rx_pkt_sn_plus_one,
    output word_out, word_out_strobe
  );
endinterface
`default_nettype wire

// File: rtl/rx_byte_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : rx_byte_word_packer
//  Description : Packs the decoded PSDU byte stream into 64-bit little-endian
//                words for the RX DMA path, then appends one trailer word
//                with the FCS result and the packet sequence number.
//                Optional feature macro: TRAILER_PKT_LEN_EN - when defined,
//                trailer bits [63:48] carry num_byte latched at pkt_start.
//  Revision    : 1.0 - initial release
// ============================================================================
module rx_byte_word_packer #(
  parameter int SN_WIDTH = 10
) (
  input  wire logic           clk,
  input  wire logic           reset,
  rx_byte_word_packer_if.slave bus
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [63:0]         acc_q,     acc_d;
  logic                pending_q, pending_d;
  logic                fcs_ok_q,  fcs_ok_d;
  logic [SN_WIDTH-1:0] sn_q,      sn_d;
  logic [63:0]         word_q,    word_d;
  logic                strobe_q,  strobe_d;
`ifdef TRAILER_PKT_LEN_EN
  logic [15:0]         pkt_len_q, pkt_len_d;
`endif

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        w_accept;
  logic        w_last_byte;
  logic        w_emit_data;
  logic        w_emit_trailer;
  logic [63:0] w_merged;
  logic [63:0] w_trailer;

  // Byte index compared in 17 bits so num_byte = 0 cannot wrap to 0xFFFF.
  assign w_last_byte = (({1'b0, bus.byte_count} + 17'd1) == {1'b0, bus.num_byte});

  // A byte is taken only if it lies inside the PSDU; pkt_start drops it.
  assign w_accept = bus.byte_in_strobe && !bus.pkt_start &&
                    (bus.byte_count < bus.num_byte);

  // Word boundary: lane 7 filled, or final byte of the packet.
  assign w_emit_data = w_accept && ((bus.byte_count[2:0] == 3'd7) || w_last_byte);

  // Trailer waits for a cycle with no data word; a new packet cancels it.
  assign w_emit_trailer = pending_q && !w_emit_data && !bus.pkt_start;

  // Accumulator with the incoming byte dropped into its lane.
  always_comb begin
    w_merged = acc_q;
    w_merged[{bus.byte_count[2:0], 3'b000} +: 8] = bus.byte_in;
  end

  // Trailer layout: fcs_ok in bit 0, sn from bit 16, optional length on top.
  always_comb begin
    w_trailer                  = 64'd0;
    w_trailer[0]               = fcs_ok_q;
    w_trailer[16 +: SN_WIDTH]  = sn_q;
`ifdef TRAILER_PKT_LEN_EN
    w_trailer[63:48]           = pkt_len_q;
`endif
  end

  // Next-state for accumulator, trailer bookkeeping and output register.
  always_comb begin
    acc_d     = acc_q;
    pending_d = pending_q;
    fcs_ok_d  = fcs_ok_q;
    sn_d      = sn_q;
    word_d    = word_q;
    strobe_d  = 1'b0;
`ifdef TRAILER_PKT_LEN_EN
    pkt_len_d = pkt_len_q;
`endif

    // Accumulator: cleared by a new packet or by each emission.
    if (bus.pkt_start) begin
      acc_d = 64'd0;
    end else if (w_emit_data) begin
      acc_d = 64'd0;
    end else if (w_accept) begin
      acc_d = w_merged;
    end

`ifdef TRAILER_PKT_LEN_EN
    if (bus.pkt_start) begin
      pkt_len_d = bus.num_byte;
    end
`endif

    // Pending flag: a strobe arriving while the trailer leaves is absorbed
    // into that trailer so only one trailer is ever produced per packet.
    if (bus.pkt_start) begin
      pending_d = 1'b0;
    end else if (w_emit_trailer) begin
      pending_d = 1'b0;
    end else if (bus.fcs_in_strobe) begin
      pending_d = 1'b1;
    end

    if (bus.fcs_in_strobe && !bus.pkt_start) begin
      fcs_ok_d = bus.fcs_ok;
    end

    if (w_emit_trailer && bus.rx_pkt_sn_plus_one) begin
      sn_d = sn_q + SN_WIDTH'(1);
    end

    // Output register: data word has priority over the trailer.
    if (w_emit_data) begin
      word_d   = w_merged;
      strobe_d = 1'b1;
    end else if (w_emit_trailer) begin
      word_d   = w_trailer;
      strobe_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= 64'd0;
      pending_q <= 1'b0;
      fcs_ok_q  <= 1'b0;
      sn_q      <= '0;
      word_q    <= 64'd0;
      strobe_q  <= 1'b0;
`ifdef TRAILER_PKT_LEN_EN
      pkt_len_q <= 16'd0;
`endif
    end else begin
      acc_q     <= acc_d;
      pending_q <= pending_d;
      fcs_ok_q  <= fcs_ok_d;
      sn_q      <= sn_d;
      word_q    <= word_d;
      strobe_q  <= strobe_d;
`ifdef TRAILER_PKT_LEN_EN
      pkt_len_q <= pkt_len_d;
`endif
    end
  end

  assign bus.word_out        = word_q;
  assign bus.word_out_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_byte_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_byte_word_packer
//  Description : Directed self-checking bench for rx_byte_word_packer
//                (instantiated with SN_WIDTH = 2 to reach the sn wrap).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_byte_word_packer;

`ifdef TRAILER_PKT_LEN_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  int          q_cyc[$];
  logic [63:0] q_word[$];

  rx_byte_word_packer_if u_if ();

  rx_byte_word_packer #(.SN_WIDTH(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output log: every strobed word with the cycle index it appeared in.
  always @(negedge clk) begin
    if (u_if.word_out_strobe === 1'b1) begin
      q_cyc.push_back(cyc);
      q_word.push_back(u_if.word_out);
    end
  end

  // Expected trailer word built from its fields.
  function automatic logic [63:0] exp_trailer(input bit ok, input int sn, input logic [15:0] len);
    logic [63:0] w;
    w = 64'(ok) | (64'(sn) << 16);
    if (LEN_EN) w = w | {len, 48'h0};
    return w;
  endfunction

  function automatic logic [63:0] log_word(input int i);
    if (i < q_word.size()) return q_word[i];
    return 64'hx;
  endfunction

  function automatic int log_cyc(input int i);
    if (i < q_cyc.size()) return q_cyc[i];
    return -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_log();
    q_cyc.delete();
    q_word.delete();
  endtask

  task automatic start_pkt(input logic [15:0] n);
    u_if.num_byte  = n;
    u_if.pkt_start = 1'b1;
    tick();
    u_if.pkt_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [15:0] c, input bit fcs,
                           input bit ok, output int t);
    u_if.byte_in        = b;
    u_if.byte_count     = c;
    u_if.byte_in_strobe = 1'b1;
    u_if.fcs_in_strobe  = fcs;
    u_if.fcs_ok         = ok;
    tick();
    t = cyc;
    u_if.byte_in_strobe = 1'b0;
    u_if.fcs_in_strobe  = 1'b0;
  endtask

  task automatic pulse_fcs(input bit ok, output int t);
    u_if.fcs_ok        = ok;
    u_if.fcs_in_strobe = 1'b1;
    tick();
    t = cyc;
    u_if.fcs_in_strobe = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    n_tests++;
    if (u_if.word_out !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_word: got %h want %h", u_if.word_out, 64'h0);
    end
    n_tests++;
    if (u_if.word_out_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobe: got %b want 0", u_if.word_out_strobe);
    end
    reset = 1'b0;
    clear_log();
    idle(2);
    n_tests++;
    if (q_word.size() != 0) begin
      n_fail++;
      $display("FAIL reset_idle_out: got %0d words want 0", q_word.size());
    end
  endtask

  task automatic test_16byte();
    int t7, t15, tf, t;
    clear_log();
    u_if.rx_pkt_sn_plus_one = 1'b0;
    start_pkt(16'd16);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(i), 16'(i), 1'b0, 1'b0, t);
      if (i == 7)  t7  = t;
      if (i == 15) t15 = t;
    end
    idle(2);
    pulse_fcs(1'b1, tf);
    idle(4);
    n_tests++;
    if (q_word.size() != 3) begin
      n_fail++;
      $display("FAIL p16_count: got %0d words want 3", q_word.size());
    end
    n_tests++;
    if (log_word(0) !== 64'h0706050403020100) begin
      n_fail++;
      $display("FAIL p16_word0: got %h want %h", log_word(0), 64'h0706050403020100);
    end
    n_tests++;
    if (log_word(1) !== 64'h0F0E0D0C0B0A0908) begin
      n_fail++;
      $display("FAIL p16_word1: got %h want %h", log_word(1), 64'h0F0E0D0C0B0A0908);
    end
    n_tests++;
    if (log_word(2) !== exp_trailer(1'b1, 0, 16'd16)) begin
      n_fail++;
      $display("FAIL p16_trailer: got %h want %h", log_word(2), exp_trailer(1'b1, 0, 16'd16));
    end
    n_tests++;
    if (log_cyc(0) != t7 || log_cyc(1) != t15 || log_cyc(2) != tf + 1) begin
      n_fail++;
      $display("FAIL p16_timing: got %0d/%0d/%0d want %0d/%0d/%0d",
               log_cyc(0), log_cyc(1), log_cyc(2), t7, t15, tf + 1);
    end
  endtask

  task automatic test_short();
    int t10, t;
    clear_log();
    start_pkt(16'd11);
    for (int i = 0; i < 11; i++) begin
      send_byte(8'hAA, 16'(i), 1'b0, 1'b0, t);
      if (i == 10) t10 = t;
    end
    send_byte(8'h55, 16'd11, 1'b0, 1'b0, t);
    idle(3);
    n_tests++;
    if (log_word(0) !== 64'hAAAAAAAAAAAAAAAA) begin
      n_fail++;
      $display("FAIL p11_word0: got %h want %h", log_word(0), 64'hAAAAAAAAAAAAAAAA);
    end
    n_tests++;
    if (log_word(1) !== 64'h0000000000AAAAAA) begin
      n_fail++;
      $display("FAIL p11_word1: got %h want %h", log_word(1), 64'h0000000000AAAAAA);
    end
    n_tests++;
    if (log_cyc(1) != t10) begin
      n_fail++;
      $display("FAIL p11_timing: got cycle %0d want %0d", log_cyc(1), t10);
    end
    n_tests++;
    if (q_word.size() != 2) begin
      n_fail++;
      $display("FAIL p11_overrun: got %0d words want 2", q_word.size());
    end
  endtask

  task automatic test_collision();
    int t15, t;
    clear_log();
    start_pkt(16'd16);
    for (int i = 0; i < 16; i++) begin
      send_byte(8'(8'h10 + i), 16'(i), (i == 15), 1'b0, t);
      if (i == 15) t15 = t;
    end
    idle(4);
    n_tests++;
    if (q_word.size() != 3) begin
      n_fail++;
      $display("FAIL coll_count: got %0d words want 3", q_word.size());
    end
    n_tests++;
    if (log_word(1) !== 64'h1F1E1D1C1B1A1918 || log_cyc(1) != t15) begin
      n_fail++;
      $display("FAIL coll_data: got %h @%0d want %h @%0d",
               log_word(1), log_cyc(1), 64'h1F1E1D1C1B1A1918, t15);
    end
    n_tests++;
    if (log_word(2) !== exp_trailer(1'b0, 0, 16'd16) || log_cyc(2) != t15 + 1) begin
      n_fail++;
      $display("FAIL coll_trailer: got %h @%0d want %h @%0d",
               log_word(2), log_cyc(2), exp_trailer(1'b0, 0, 16'd16), t15 + 1);
    end
  endtask

  task automatic test_sn_increment();
    int t;
    int exp_sn[5] = '{0, 1, 2, 3, 0};
    u_if.rx_pkt_sn_plus_one = 1'b1;
    for (int p = 0; p < 5; p++) begin
      clear_log();
      start_pkt(16'd1);
      send_byte(8'h5A, 16'd0, 1'b0, 1'b0, t);
      pulse_fcs(1'b1, t);
      idle(3);
      n_tests++;
      if (log_word(0) !== 64'h5A || log_word(1) !== exp_trailer(1'b1, exp_sn[p], 16'd1)) begin
        n_fail++;
        $display("FAIL sn_inc_pkt%0d: got %h,%h want %h,%h", p, log_word(0), log_word(1),
                 64'h5A, exp_trailer(1'b1, exp_sn[p], 16'd1));
      end
    end
  endtask

  task automatic test_sn_hold();
    int t;
    u_if.rx_pkt_sn_plus_one = 1'b0;
    for (int p = 0; p < 2; p++) begin
      clear_log();
      start_pkt(16'd1);
      send_byte(8'h33, 16'd0, 1'b0, 1'b0, t);
      pulse_fcs(1'b1, t);
      idle(3);
      n_tests++;
      if (log_word(1) !== exp_trailer(1'b1, 1, 16'd1)) begin
        n_fail++;
        $display("FAIL sn_hold_pkt%0d: got %h want %h", p, log_word(1),
                 exp_trailer(1'b1, 1, 16'd1));
      end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    start_pkt(16'd20);
    for (int i = 0; i < 5; i++) send_byte(8'hEE, 16'(i), 1'b0, 1'b0, t);
    pulse_fcs(1'b1, t);
    clear_log();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (q_word.size() != 0 || u_if.word_out !== 64'h0) begin
      n_fail++;
      $display("FAIL rst_mid_abort: got %0d words, word %h want 0 words, word 0",
               q_word.size(), u_if.word_out);
    end
    clear_log();
    start_pkt(16'd8);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 16'(i), 1'b0, 1'b0, t);
    idle(4);
    n_tests++;
    if (q_word.size() != 1 || log_word(0) !== 64'h0807060504030201) begin
      n_fail++;
      $display("FAIL rst_mid_new: got %0d words, first %h want 1 word %h",
               q_word.size(), log_word(0), 64'h0807060504030201);
    end
  endtask

  task automatic test_zero_len();
    int t;
    clear_log();
    start_pkt(16'd0);
    send_byte(8'h77, 16'd0, 1'b0, 1'b0, t);
    send_byte(8'h78, 16'd1, 1'b0, 1'b0, t);
    idle(3);
    n_tests++;
    if (q_word.size() != 0) begin
      n_fail++;
      $display("FAIL zero_len: got %0d words want 0", q_word.size());
    end
  endtask

  task automatic test_pkt_len();
    int t;
    clear_log();
    start_pkt(16'h05DC);
    idle(1);
    pulse_fcs(1'b0, t);
    idle(3);
    n_tests++;
    if (q_word.size() != 1 || log_word(0) !== exp_trailer(1'b0, 0, 16'h05DC)) begin
      n_fail++;
      $display("FAIL pkt_len_trailer: got %0d words, %h want 1 word %h",
               q_word.size(), log_word(0), exp_trailer(1'b0, 0, 16'h05DC));
    end
  endtask

  initial begin
    reset                   = 1'b1;
    u_if.pkt_start          = 1'b0;
    u_if.byte_in            = 8'h00;
    u_if.byte_in_strobe     = 1'b0;
    u_if.byte_count         = 16'h0;
    u_if.num_byte           = 16'h0;
    u_if.fcs_in_strobe      = 1'b0;
    u_if.fcs_ok             = 1'b0;
    u_if.rx_pkt_sn_plus_one = 1'b0;

    test_reset();
    test_16byte();
    test_short();
    test_collision();
    test_sn_increment();
    test_sn_hold();
    test_reset_mid();
    test_zero_len();
    test_pkt_len();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
